// File: rtl/reg_pkg.sv
// reg_pkg: shared defaults for the parallel load register
package reg_pkg;
   localparam int          DEFAULT_WIDTH = 8;
   localparam logic [63:0] DEFAULT_RESET = '0;
endpackage

// File: rtl/load_register.sv
// load_register: WIDTH-bit register with synchronous reset and load enable
module load_register
   import reg_pkg::*;
#(
   parameter int          WIDTH       = DEFAULT_WIDTH,
   parameter logic [63:0] RESET_VALUE = DEFAULT_RESET
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_en,
   input  logic [WIDTH-1:0] par_in,
   output logic [WIDTH-1:0] par_out
);
   // reject widths outside 1..64 and reset values with bits above WIDTH
   if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
      $error("load_register: WIDTH must be 1..64");
   end else if (WIDTH < 64 && (RESET_VALUE >> WIDTH) != 64'd0) begin : g_bad_reset
      $error("load_register: RESET_VALUE does not fit in WIDTH bits");
   end
   always_ff @(posedge clk)
      par_out <= rst ? RESET_VALUE[WIDTH-1:0] : load_en ? par_in : par_out;
endmodule

// File: tb/tb_load_register.sv
// tb_load_register: directed checks of load, hold, reset priority and latency
module tb_load_register;
   logic       clk = 1'b0;
   logic       rst;
   logic       load_en;
   logic [7:0] par_in;
   logic [7:0] par_out;
   int         n_checks = 0;
   int         n_fails  = 0;

   load_register #(.WIDTH(8), .RESET_VALUE(64'd0)) dut (
      .clk(clk),
      .rst(rst),
      .load_en(load_en),
      .par_in(par_in),
      .par_out(par_out)
   );

   always #50 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1;
      load_en = 1'b0;
      par_in = 8'h00;
      tick();
      tick();
      check("reset", par_out, 8'h00);
      rst = 1'b0;
      load_en = 1'b1;
      par_in = 8'd17;
      #40;
      check("no_comb_path", par_out, 8'h00);
      tick();
      check("load17", par_out, 8'd17);
      tick();
      check("load17_stable", par_out, 8'd17);
      par_in = 8'hA5;
      tick();
      check("load_a5", par_out, 8'hA5);
      load_en = 1'b0;
      par_in = 8'h3C;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hold_a5", par_out, 8'hA5);
      end
      load_en = 1'b1;
      par_in = 8'h55;
      tick();
      check("load_55", par_out, 8'h55);
      rst = 1'b1;
      par_in = 8'hFF;
      tick();
      check("reset_priority", par_out, 8'h00);
      rst = 1'b0;
      par_in = 8'h55;
      tick();
      check("load_after_reset", par_out, 8'h55);
      load_en = 1'b0;
      #20;
      rst = 1'b1;
      #10;
      check("sync_reset_mid", par_out, 8'h55);
      rst = 1'b0;
      tick();
      check("sync_reset_edge", par_out, 8'h55);
      load_en = 1'b1;
      par_in = 8'h00;
      #40;
      check("b2b_pre_edge", par_out, 8'h55);
      tick();
      check("b2b_00", par_out, 8'h00);
      par_in = 8'hFF;
      tick();
      check("b2b_ff", par_out, 8'hFF);
      par_in = 8'h01;
      #40;
      check("b2b_ff_stable", par_out, 8'hFF);
      tick();
      check("b2b_01", par_out, 8'h01);
      load_en = 1'b0;
      par_in = 8'hC3;
      tick();
      check("hold_01", par_out, 8'h01);
      rst = 1'b1;
      load_en = 1'b0;
      tick();
      check("reset_mid_op", par_out, 8'h00);
      rst = 1'b0;
      tick();
      check("hold_after_reset", par_out, 8'h00);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
